// File: rtl/fp_pkg.sv
// fp_pkg: shared constants, lane encodings and FSM states for the fp64-to-fp32 packer.
package fp_pkg;
  localparam int FP64_BIAS = 1023;
  localparam int FP32_BIAS = 127;
  localparam int BIAS_DELTA = FP64_BIAS - FP32_BIAS;
  localparam logic [31:0] QNAN32 = 32'h7FC00000;
  localparam logic [31:0] INF32 = 32'h7F800000;
  localparam logic [1:0] LANES_FP64 = 2'b00;
  localparam logic [1:0] LANES_LO = 2'b01;
  localparam logic [1:0] LANES_PAIR = 2'b11;
  typedef enum logic [2:0] {IDLE, CLASSIFY, DENORM, ROUND, EMIT} state_e;
endpackage

// File: rtl/fp32_rne_round.sv
// fp32_rne_round: round-to-nearest-even of an fp32 exponent/mantissa with guard, round and sticky.
module fp32_rne_round (
  input  logic        sign,
  input  logic [7:0]  exp_in,
  input  logic [22:0] man_in,
  input  logic        guard,
  input  logic        round,
  input  logic        sticky,
  output logic [31:0] result
);
  logic        inc;
  logic [30:0] mag;
  assign inc = guard & (round | sticky | man_in[0]);
  // A single add lets mantissa carries ripple into the exponent, reaching inf or exponent 1 as needed.
  assign mag = {exp_in, man_in} + 31'(inc);
  assign result = {sign, mag};
endmodule

// File: rtl/double_to_single_packer.sv
// double_to_single_packer: passes fp64 through or converts to fp32 and packs two lanes per output word.
module double_to_single_packer
  import fp_pkg::*;
#(
  parameter bit SUB_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic        mode,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic [1:0]  out_lanes
);
  state_e             state_q, state_d;
  logic               pending_q, pending_d;
  logic [31:0]        lo_q, lo_d;
  logic [63:0]        x_q, x_d;
  logic               sign_q, sign_d;
  logic [7:0]         exp_q, exp_d;
  logic [23:0]        sig_q, sig_d;
  logic               g_q, g_d, r_q, r_d, s_q, s_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [63:0]        out_data_q, out_data_d;
  logic [1:0]         out_lanes_q, out_lanes_d;
  logic [10:0]        e;
  logic [51:0]        m;
  logic signed [12:0] eb;
  logic [31:0]        rnd;
  logic               cut_in;
  assign e = x_q[62:52];
  assign m = x_q[51:0];
  assign eb = $signed({2'b00, e}) - 13'(BIAS_DELTA);
  assign cut_in = pending_q && (flush || (in_valid && !mode));
  assign in_ready = !rst && state_q == IDLE && !cut_in;
  assign out_valid = !rst && state_q == EMIT;
  assign out_data = out_data_q;
  assign out_lanes = out_lanes_q;
  fp32_rne_round u_round (
    .sign  (sign_q),
    .exp_in(exp_q),
    .man_in(sig_q[22:0]),
    .guard (g_q),
    .round (r_q),
    .sticky(s_q),
    .result(rnd)
  );
  always_comb begin
    state_d = state_q;
    pending_d = pending_q;
    lo_d = lo_q;
    x_d = x_q;
    sign_d = sign_q;
    exp_d = exp_q;
    sig_d = sig_q;
    g_d = g_q;
    r_d = r_q;
    s_d = s_q;
    cnt_d = cnt_q;
    out_data_d = out_data_q;
    out_lanes_d = out_lanes_q;
    case (state_q)
      IDLE: begin
        if (cut_in) begin
          state_d = EMIT;
          out_data_d = {32'h0, lo_q};
          out_lanes_d = LANES_LO;
        end else if (in_valid) begin
          x_d = in_data;
          state_d = mode ? CLASSIFY : EMIT;
          out_data_d = mode ? out_data_q : in_data;
          out_lanes_d = mode ? out_lanes_q : LANES_FP64;
        end
      end
      CLASSIFY: begin
        sign_d = x_q[63];
        exp_d = 8'h00;
        sig_d = 24'h0;
        g_d = 1'b0;
        r_d = 1'b0;
        s_d = 1'b0;
        state_d = ROUND;
        // Specials are encoded as exact fp32 fields with zero GRS so the rounder passes them unchanged.
        if (e == 11'h7FF) begin
          exp_d = INF32[30:23];
          sig_d = (m != 52'h0) ? {1'b0, QNAN32[22:0]} : 24'h0;
        end else if (e == 11'h0 || eb < -13'sd24) begin
          exp_d = 8'h00;
        end else if (eb >= 13'sd255) begin
          exp_d = INF32[30:23];
        end else if (eb >= 13'sd1) begin
          exp_d = eb[7:0];
          sig_d = {1'b1, m[51:29]};
          g_d = m[28];
          r_d = m[27];
          s_d = |m[26:0];
        end else if (SUB_EN) begin
          sig_d = {1'b1, m[51:29]};
          g_d = m[28];
          r_d = m[27];
          s_d = |m[26:0];
          cnt_d = 5'(13'sd1 - eb);
          state_d = DENORM;
        end
      end
      DENORM: begin
        sig_d = sig_q >> 1;
        g_d = sig_q[0];
        r_d = g_q;
        s_d = s_q | r_q;
        cnt_d = cnt_q - 5'd1;
        state_d = (cnt_q == 5'd1) ? ROUND : DENORM;
      end
      ROUND: begin
        if (pending_q) begin
          out_data_d = {rnd, lo_q};
          out_lanes_d = LANES_PAIR;
          state_d = EMIT;
        end else begin
          lo_d = rnd;
          pending_d = 1'b1;
          state_d = IDLE;
        end
      end
      EMIT: begin
        if (out_ready) begin
          pending_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pending_q <= 1'b0;
      lo_q <= 32'h0;
      x_q <= 64'h0;
      sign_q <= 1'b0;
      exp_q <= 8'h0;
      sig_q <= 24'h0;
      g_q <= 1'b0;
      r_q <= 1'b0;
      s_q <= 1'b0;
      cnt_q <= 5'h0;
      out_data_q <= 64'h0;
      out_lanes_q <= LANES_FP64;
    end else begin
      state_q <= state_d;
      pending_q <= pending_d;
      lo_q <= lo_d;
      x_q <= x_d;
      sign_q <= sign_d;
      exp_q <= exp_d;
      sig_q <= sig_d;
      g_q <= g_d;
      r_q <= r_d;
      s_q <= s_d;
      cnt_q <= cnt_d;
      out_data_q <= out_data_d;
      out_lanes_q <= out_lanes_d;
    end
  end
endmodule

// File: tb/tb_double_to_single_packer.sv
// tb_double_to_single_packer: table-driven vectors plus hand-written pending, flush, backpressure and reset sequences.
module tb_double_to_single_packer;
  logic clk = 0, rst = 1, in_valid = 0, in_ready, mode = 0, flush = 0, out_valid, out_ready = 1;
  logic [63:0] in_data = 0, out_data;
  logic [1:0] out_lanes;
  logic v0 = 0, r0, m0 = 1, f0 = 0, ov0;
  logic [63:0] d0 = 0, od0;
  logic [1:0] ol0;
  int checks = 0, failures = 0;
  typedef struct {logic [63:0] d; logic [1:0] l;} exp_t;
  typedef struct {logic [63:0] in; logic [31:0] res;} vec_t;
  exp_t sb[$];
  vec_t vecs[16];

  double_to_single_packer #(.SUB_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .mode(mode),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_lanes(out_lanes)
  );
  double_to_single_packer #(.SUB_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(v0), .in_ready(r0), .in_data(d0), .mode(m0),
    .flush(f0), .out_valid(ov0), .out_ready(1'b1), .out_data(od0), .out_lanes(ol0)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [65:0] got, input logic [65:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out got=%h lanes=%b", out_data, out_lanes);
      end else begin
        exp_t x;
        x = sb.pop_front();
        check("out_word", {out_lanes, out_data}, {x.l, x.d});
      end
    end
  end

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] d, input logic md);
    int n = 0;
    in_valid = 1;
    in_data = d;
    mode = md;
    #1;
    while (!in_ready && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) check("send_timeout", 66'(in_ready), 66'd1);
    @(posedge clk);
    #1;
    in_valid = 0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!out_valid) check("out_timeout", 66'(out_valid), 66'd1);
  endtask

  task automatic wait_idle;
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) check("idle_timeout", 66'(in_ready), 66'd1);
  endtask

  task automatic drain;
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", 66'(sb.size()), 66'd0);
  endtask

  initial begin
    int n;
    bit seen;
    vecs[0]  = '{64'h3FF0000000000000, 32'h3F800000};
    vecs[1]  = '{64'hC000000000000000, 32'hC0000000};
    vecs[2]  = '{64'h3FF0000010000000, 32'h3F800000};
    vecs[3]  = '{64'h3FF0000030000000, 32'h3F800002};
    vecs[4]  = '{64'h47EFFFFFF0000000, 32'h7F800000};
    vecs[5]  = '{64'h7FF8000000000000, 32'h7FC00000};
    vecs[6]  = '{64'hFFF0000000000000, 32'hFF800000};
    vecs[7]  = '{64'h8000000000000000, 32'h80000000};
    vecs[8]  = '{64'h36A0000000000000, 32'h00000001};
    vecs[9]  = '{64'h3690000000000000, 32'h00000000};
    vecs[10] = '{64'hB6A0000000000000, 32'h80000001};
    vecs[11] = '{64'h47F0000000000000, 32'h7F800000};
    vecs[12] = '{64'h3810000000000000, 32'h00800000};
    vecs[13] = '{64'h380FFFFFF0000000, 32'h00800000};
    vecs[14] = '{64'h3FF0000018000000, 32'h3F800001};
    vecs[15] = '{64'h7FF0000000000001, 32'h7FC00000};
    tick(3);
    check("rst_in_ready", 66'(in_ready), 66'd0);
    check("rst_out_valid", 66'(out_valid), 66'd0);
    rst = 0;
    #1;
    check("post_rst_in_ready", 66'(in_ready), 66'd1);
    check("post_rst_out", {out_lanes, out_data}, 66'd0);
    sb.push_back('{64'h3FF0000000000000, 2'b00});
    send(64'h3FF0000000000000, 1'b0);
    wait_out(n);
    check("lat_mode0", 66'(n + 1), 66'd1);
    drain;
    for (int i = 0; i < 16; i += 2) begin
      sb.push_back('{{vecs[i+1].res, vecs[i].res}, 2'b11});
      send(vecs[i].in, 1'b1);
      send(vecs[i+1].in, 1'b1);
      drain;
    end
    sb.push_back('{64'hC0000000_3F800000, 2'b11});
    send(64'h3FF0000000000000, 1'b1);
    send(64'hC000000000000000, 1'b1);
    wait_out(n);
    check("lat_pair", 66'(n + 1), 66'd3);
    drain;
    sb.push_back('{64'h00000001_3F800000, 2'b11});
    send(64'h3FF0000000000000, 1'b1);
    send(64'h36A0000000000000, 1'b1);
    wait_out(n);
    check("lat_denorm23", 66'(n + 1), 66'd26);
    drain;
    flush = 1;
    tick(1);
    check("flush_not_pending", 66'(out_valid), 66'd0);
    flush = 0;
    sb.push_back('{64'h00000000_3F800000, 2'b01});
    send(64'h3FF0000000000000, 1'b1);
    wait_idle;
    flush = 1;
    #1;
    check("flush_in_ready", 66'(in_ready), 66'd0);
    tick(1);
    flush = 0;
    check("flush_valid", 66'(out_valid), 66'd1);
    drain;
    sb.push_back('{64'h00000000_40000000, 2'b01});
    sb.push_back('{64'h3FF0000000000000, 2'b00});
    send(64'h4000000000000000, 1'b1);
    wait_idle;
    in_valid = 1;
    in_data = 64'h3FF0000000000000;
    mode = 0;
    #1;
    check("pend_mode0_in_ready", 66'(in_ready), 66'd0);
    send(64'h3FF0000000000000, 1'b0);
    drain;
    sb.push_back('{64'h00000000_C0000000, 2'b01});
    sb.push_back('{64'h4000000000000000, 2'b00});
    send(64'hC000000000000000, 1'b1);
    wait_idle;
    flush = 1;
    send(64'h4000000000000000, 1'b0);
    flush = 0;
    drain;
    out_ready = 0;
    sb.push_back('{64'h40000000_3F800000, 2'b11});
    send(64'h3FF0000000000000, 1'b1);
    send(64'h4000000000000000, 1'b1);
    wait_out(n);
    for (int k = 0; k < 5; k++) begin
      tick(1);
      check("bp_valid", 66'(out_valid), 66'd1);
      check("bp_data", {out_lanes, out_data}, {2'b11, 64'h40000000_3F800000});
      check("bp_in_ready", 66'(in_ready), 66'd0);
    end
    out_ready = 1;
    drain;
    send(64'h3FF0000000000000, 1'b1);
    send(64'h36A0000000000000, 1'b1);
    tick(5);
    rst = 1;
    tick(2);
    rst = 0;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      tick(1);
      if (out_valid) seen = 1;
    end
    check("rst_denorm_quiet", 66'(seen), 66'd0);
    sb.push_back('{64'h3F800000_40000000, 2'b11});
    send(64'h4000000000000000, 1'b1);
    send(64'h3FF0000000000000, 1'b1);
    drain;
    out_ready = 0;
    send(64'h1234567812345678, 1'b0);
    wait_out(n);
    rst = 1;
    tick(1);
    rst = 0;
    #1;
    check("rst_emit_valid", 66'(out_valid), 66'd0);
    out_ready = 1;
    tick(3);
    check("rst_emit_drop", 66'(sb.size()), 66'd0);
    v0 = 1;
    d0 = 64'h36A0000000000000;
    n = 0;
    while (!r0 && n < 100) begin tick(1); n++; end
    tick(1);
    v0 = 0;
    n = 0;
    while (!r0 && n < 100) begin tick(1); n++; end
    check("sub0_idle", 66'(r0), 66'd1);
    f0 = 1;
    tick(1);
    f0 = 0;
    check("sub0_valid", 66'(ov0), 66'd1);
    check("sub0_word", {ol0, od0}, {2'b01, 64'h0});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
